snake_ctrl: RTL and testbench

Game sequencer for the snake game. Sits between the debounced direction keys and the snake body datapath: it runs the IDLE/PLAY/DEAD state machine, arbitrates key presses into a single legal heading, paces moves with a programmable tick, issues one move per tick over a req/ack handshake, and keeps the score. The VGA renderer reads `game_state` and `score`; the body datapath consumes `step_req`, `step_dir` and `clear_req`.

---
 rtl/snake_ctrl.sv | 118 +++++++++++
 tb/tb_snake_ctrl.sv | 131 +++++++++++++
 2 files changed

// File: rtl/snake_ctrl.sv
// snake_ctrl: snake game sequencer (IDLE/PLAY/DEAD, key steering, move pacing, req/ack moves, score); optional SNAKE_SPEEDUP_EN shortens the interval per food
module snake_ctrl #(
  parameter logic [31:0] TICK_DIV   = 32'd25_000_000,
  parameter logic [31:0] SPEED_STEP = 32'd1_000_000,
  parameter logic [31:0] MIN_DIV    = 32'd5_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_up,
  input  logic       key_down,
  input  logic       key_left,
  input  logic       key_right,
  output logic       step_req,
  output logic [1:0] step_dir,
  input  logic       step_ack,
  input  logic       hit_wall,
  input  logic       hit_self,
  input  logic       ate_food,
  output logic       clear_req,
  output logic [1:0] game_state,
  output logic [7:0] score
);
  typedef enum logic [1:0] {IDLE = 2'd0, PLAY = 2'd1, DEAD = 2'd2} state_t;
  state_t state, state_n;
  logic [3:0] keys, key_q, edges;
  logic       any_edge, req_n, clear_n;
  logic [1:0] win, pend, pend_n, comm, comm_n, dir_n;
  logic [31:0] cnt, cnt_n, interval;
  logic [7:0] score_n;
  assign keys       = {key_right, key_left, key_down, key_up};
  assign edges      = keys & ~key_q;
  assign any_edge   = |edges;
  assign win        = edges[0] ? 2'd0 : edges[1] ? 2'd1 : edges[2] ? 2'd2 : 2'd3;
  assign game_state = state;
`ifdef SNAKE_SPEEDUP_EN
  logic [31:0] interval_n;
  // move interval: restored on each new game, shortened towards MIN_DIV per food
  always_ff @(posedge clk or posedge rst)
    if (rst) interval <= TICK_DIV;
    else     interval <= interval_n;
`else
  logic unused_params;
  assign interval      = TICK_DIV;
  assign unused_params = ^{SPEED_STEP, MIN_DIV};
`endif
  // state, heading, tick counter, handshake and score registers
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state     <= IDLE;
      key_q     <= '0;
      pend      <= 2'd3;
      comm      <= 2'd3;
      cnt       <= '0;
      step_req  <= 1'b0;
      step_dir  <= 2'd3;
      clear_req <= 1'b0;
      score     <= '0;
    end else begin
      state     <= state_n;
      key_q     <= keys;
      pend      <= pend_n;
      comm      <= comm_n;
      cnt       <= cnt_n;
      step_req  <= req_n;
      step_dir  <= dir_n;
      clear_req <= clear_n;
      score     <= score_n;
    end
  // next state: game start/stop, steering with reversal guard, tick pacing, ack handling
  always_comb begin
    state_n = state;
    pend_n  = pend;
    comm_n  = comm;
    cnt_n   = cnt;
    req_n   = step_req;
    dir_n   = step_dir;
    clear_n = 1'b0;
    score_n = score;
`ifdef SNAKE_SPEEDUP_EN
    interval_n = interval;
`endif
    unique case (state)
      IDLE: if (any_edge) begin
        state_n = PLAY;
        pend_n  = win;
        comm_n  = win;
        score_n = '0;
        cnt_n   = '0;
        clear_n = 1'b1;
`ifdef SNAKE_SPEEDUP_EN
        interval_n = TICK_DIV;
`endif
      end
      PLAY: begin
        if (any_edge && win != (comm ^ 2'd1)) pend_n = win;
        if (!step_req) begin
          if (cnt == interval - 32'd1) begin
            cnt_n  = '0;
            req_n  = 1'b1;
            dir_n  = pend;
            comm_n = pend;
          end else cnt_n = cnt + 32'd1;
        end else if (step_ack) begin
          req_n = 1'b0;
          if (hit_wall || hit_self) state_n = DEAD;
          else if (ate_food) begin
            score_n = score + {7'd0, score != 8'hff};
`ifdef SNAKE_SPEEDUP_EN
            interval_n = (interval - MIN_DIV >= SPEED_STEP) ? interval - SPEED_STEP : MIN_DIV;
`endif
          end
        end
      end
      DEAD: if (any_edge) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end
endmodule

// File: tb/tb_snake_ctrl.sv
// tb_snake_ctrl: directed self-checking bench for snake_ctrl (TICK_DIV=8, SPEED_STEP=2, MIN_DIV=4)
module tb_snake_ctrl;
  logic clk = 1'b0, rst = 1'b1;
  logic key_up = 1'b0, key_down = 1'b0, key_left = 1'b0, key_right = 1'b0;
  logic step_ack = 1'b0, hit_wall = 1'b0, hit_self = 1'b0, ate_food = 1'b0;
  logic step_req, clear_req;
  logic [1:0] step_dir, game_state;
  logic [7:0] score;
  int tests = 0, fails = 0, n;
`ifdef SNAKE_SPEEDUP_EN
  localparam int P2 = 6, P3 = 4, P4 = 4, PS = 4;
`else
  localparam int P2 = 8, P3 = 8, P4 = 8, PS = 8;
`endif
  always #5 clk = ~clk;
  snake_ctrl #(.TICK_DIV(32'd8), .SPEED_STEP(32'd2), .MIN_DIV(32'd4)) dut (
    .clk(clk), .rst(rst), .key_up(key_up), .key_down(key_down), .key_left(key_left),
    .key_right(key_right), .step_req(step_req), .step_dir(step_dir), .step_ack(step_ack),
    .hit_wall(hit_wall), .hit_self(hit_self), .ate_food(ate_food), .clear_req(clear_req),
    .game_state(game_state), .score(score)
  );
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask
  task automatic wait_req(input int bound, output int cnt);
    cnt = 0;
    while (step_req !== 1'b1 && cnt < bound) begin
      @(negedge clk);
      cnt++;
    end
  endtask
  task automatic move(input string tag, input int exp_n, input logic [1:0] exp_dir,
                      input logic food, input logic wall, input logic self_hit);
    int k;
    wait_req(100, k);
    check({tag, "_period"}, k, exp_n);
    check({tag, "_dir"}, step_dir, exp_dir);
    @(negedge clk);
    check({tag, "_hold"}, step_req, 1);
    step_ack = 1'b1; ate_food = food; hit_wall = wall; hit_self = self_hit;
    @(negedge clk);
    step_ack = 1'b0; ate_food = 1'b0; hit_wall = 1'b0; hit_self = 1'b0;
    check({tag, "_drop"}, step_req, 0);
  endtask
  task automatic feed();
    int k;
    wait_req(100, k);
    @(negedge clk);
    step_ack = 1'b1; ate_food = 1'b1;
    @(negedge clk);
    step_ack = 1'b0; ate_food = 1'b0;
  endtask
  initial begin
    repeat (2) @(negedge clk);
    check("rst_req", step_req, 0);
    check("rst_dir", step_dir, 3);
    check("rst_clear", clear_req, 0);
    check("rst_state", game_state, 0);
    check("rst_score", score, 0);
    rst = 1'b0;
    @(negedge clk);
    check("idle_hold", game_state, 0);
    key_right = 1'b1;
    @(negedge clk);
    key_right = 1'b0;
    check("start_state", game_state, 1);
    check("start_clear", clear_req, 1);
    @(negedge clk);
    check("start_clear_end", clear_req, 0);
    move("m1", 7, 3, 0, 0, 0);
    move("m2", 8, 3, 0, 0, 0);
    key_left = 1'b1; @(negedge clk); key_left = 1'b0; @(negedge clk);
    move("reverse", 6, 3, 0, 0, 0);
    key_up = 1'b1; @(negedge clk); key_up = 1'b0; @(negedge clk);
    key_down = 1'b1; @(negedge clk); key_down = 1'b0; @(negedge clk);
    move("last_wins", 4, 1, 0, 0, 0);
    move("food1", 8, 1, 1, 0, 0);
    check("score1", score, 1);
    move("food2", P2, 1, 1, 0, 0);
    check("score2", score, 2);
    move("food3", P3, 1, 1, 0, 0);
    check("score3", score, 3);
    move("die", P4, 1, 1, 0, 1);
    check("dead_state", game_state, 2);
    check("dead_score", score, 3);
    wait_req(20, n);
    check("dead_no_req", n, 20);
    key_up = 1'b1; @(negedge clk);
    check("dead_to_idle", game_state, 0);
    key_up = 1'b0; @(negedge clk);
    check("idle_wait", game_state, 0);
    key_left = 1'b1; @(negedge clk);
    check("restart_state", game_state, 1);
    check("restart_score", score, 0);
    check("restart_clear", clear_req, 1);
    key_left = 1'b0; @(negedge clk);
    move("restart", 7, 2, 0, 0, 0);
    rst = 1'b1; @(negedge clk); rst = 1'b0; @(negedge clk);
    key_down = 1'b1; key_left = 1'b1; @(negedge clk);
    check("simul_state", game_state, 1);
    key_down = 1'b0; key_left = 1'b0; @(negedge clk);
    move("simul", 7, 1, 0, 0, 0);
    for (int i = 0; i < 254; i++) feed();
    check("score254", score, 254);
    feed();
    check("score255", score, 255);
    feed();
    check("score_sat", score, 255);
    wait_req(100, n);
    check("pre_rst_period", n, PS);
    rst = 1'b1;
    #1;
    check("async_rst_req", step_req, 0);
    check("async_rst_state", game_state, 0);
    check("async_rst_score", score, 0);
    @(negedge clk);
    rst = 1'b0; step_ack = 1'b1;
    @(negedge clk);
    step_ack = 1'b0;
    check("stale_ack_req", step_req, 0);
    check("stale_ack_state", game_state, 0);
    check("stale_ack_score", score, 0);
    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
